// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the TDM FIR sequencer: state encoding and a
// ceil-log2 helper used for parameter range checking.
package fir_ctrl_pkg;

  // Sequencer states, cycled in this order for every sample.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int ceil_log2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_tdm_ctrl_cnt_mod.sv
// Modulo counter for the tap index: synchronous clear, count enable and a
// terminal-count flag; wraps back to zero after the terminal value.
module cnt_mod #(
  parameter int gp_modulus = 16,
  parameter int gp_width   = 4
) (
  input  logic                clk,
  input  logic                rst_an,
  input  logic                clr,
  input  logic                ena,
  output logic [gp_width-1:0] count,
  output logic                tc
);

  localparam logic [gp_width-1:0] LAST = gp_width'(gp_modulus - 1);
  localparam logic [gp_width-1:0] ZERO = {gp_width{1'b0}};
  localparam logic [gp_width-1:0] ONE  = gp_width'(1'b1);

  logic [gp_width-1:0] count_r;

  // Count register: reset/clear to zero, otherwise advance and wrap on enable.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      count_r <= ZERO;
    end else if (clr) begin
      count_r <= ZERO;
    end else if (ena) begin
      count_r <= (count_r == LAST) ? ZERO : (count_r + ONE);
    end
  end

  assign count = count_r;
  assign tc    = (count_r == LAST);

endmodule

// File: rtl/fir_tdm_ctrl.sv
// Control sequencer for a time-multiplexed FIR filter: accepts a sample,
// pulses the delay-line shift, walks the tap address through a clear-then-
// accumulate MAC pass, and holds the result valid until downstream takes it.
module fir_tdm_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int gp_taps       = 16,
  parameter int gp_addr_width = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_an,
  input  logic                     i_ena,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_shift_ena,
  output logic [gp_addr_width-1:0] o_tap_addr,
  output logic                     o_acc_clr,
  output logic                     o_acc_ena,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_busy
);

  localparam logic [gp_addr_width-1:0] ADDR_ZERO = {gp_addr_width{1'b0}};

  // Tap count must be 1..2**gp_addr_width so every tap is addressable.
  generate
    if (gp_taps < 1 || ceil_log2(gp_taps) > gp_addr_width) begin : g_bad_taps
      $error("fir_tdm_ctrl: gp_taps out of range for gp_addr_width");
    end
  endgenerate

  state_t                   state_r;
  state_t                   state_nxt;
  logic                     cnt_clr;
  logic                     cnt_ena;
  logic                     cnt_tc;
  logic [gp_addr_width-1:0] cnt_val;

  cnt_mod #(
    .gp_modulus (gp_taps),
    .gp_width   (gp_addr_width)
  ) u_tap_cnt (
    .clk    (i_clk),
    .rst_an (i_rst_an),
    .clr    (cnt_clr),
    .ena    (cnt_ena),
    .count  (cnt_val),
    .tc     (cnt_tc)
  );

  // State register with synchronous active-low reset to IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and counter control; nothing advances while i_ena is low.
  always_comb begin
    state_nxt = state_r;
    cnt_clr   = 1'b0;
    cnt_ena   = 1'b0;
    if (i_ena) begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          cnt_clr   = 1'b1;
          state_nxt = ST_MAC;
        end
        ST_MAC: begin
          cnt_ena = 1'b1;
          if (cnt_tc) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_MAC;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DONE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Output decode of registered state; strobes are qualified by enable and
  // everything is quiet while reset is asserted.
  always_comb begin
    o_ready     = 1'b0;
    o_shift_ena = 1'b0;
    o_acc_clr   = 1'b0;
    o_acc_ena   = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_tap_addr  = ADDR_ZERO;
    if (i_rst_an) begin
      o_busy      = (state_r != ST_IDLE);
      o_out_valid = (state_r == ST_DONE);
      if (state_r == ST_MAC) begin
        o_tap_addr = cnt_val;
      end else begin
        o_tap_addr = ADDR_ZERO;
      end
      if (i_ena) begin
        o_ready     = (state_r == ST_IDLE);
        o_shift_ena = (state_r == ST_SHIFT);
        o_acc_clr   = (state_r == ST_MAC) && (cnt_val == ADDR_ZERO);
        o_acc_ena   = (state_r == ST_MAC) && (cnt_val != ADDR_ZERO);
      end else begin
        o_ready     = 1'b0;
        o_shift_ena = 1'b0;
        o_acc_clr   = 1'b0;
        o_acc_ena   = 1'b0;
      end
    end else begin
      o_busy      = 1'b0;
      o_out_valid = 1'b0;
      o_tap_addr  = ADDR_ZERO;
    end
  end

endmodule

// File: tb/tb_fir_tdm_ctrl.sv
// Scoreboard bench for fir_tdm_ctrl: a 4-tap and a 1-tap instance share one
// stimulus stream; a per-cycle reference model pushes expected outputs into
// queues and a negedge monitor pops and compares them.
module tb_fir_tdm_ctrl;

  localparam int T0 = 4;
  localparam int T1 = 1;
  localparam int AW = 4;

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          shift;
    logic          clr;
    logic          acc;
    logic          outv;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_an    = 1'b0;
  logic ena       = 1'b0;
  logic valid     = 1'b0;
  logic out_ready = 1'b0;

  logic rdy0, shift0, clr0, acc0, ov0, busy0;
  logic rdy1, shift1, clr1, acc1, ov1, busy1;
  logic [AW-1:0] addr0, addr1;

  fir_tdm_ctrl #(.gp_taps(T0), .gp_addr_width(AW)) dut0 (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_valid(valid),
    .o_ready(rdy0), .o_shift_ena(shift0), .o_tap_addr(addr0),
    .o_acc_clr(clr0), .o_acc_ena(acc0), .o_out_valid(ov0),
    .i_out_ready(out_ready), .o_busy(busy0)
  );

  fir_tdm_ctrl #(.gp_taps(T1), .gp_addr_width(AW)) dut1 (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_valid(valid),
    .o_ready(rdy1), .o_shift_ena(shift1), .o_tap_addr(addr1),
    .o_acc_clr(clr1), .o_acc_ena(acc1), .o_out_valid(ov1),
    .i_out_ready(out_ready), .o_busy(busy1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int hs0 = 0;
  int hs1 = 0;
  int cyc = 0;
  int pos0 = 0;
  int pos1 = 0;

  // Reference model: pos counts enabled cycles since acceptance
  // (0 idle, 1 shift, 2..taps+1 tap pos-2, taps+2 result waiting).
  function automatic exp_t expect_of(input int pos, input int taps,
                                     input logic r, input logic e);
    exp_t x;
    x = '0;
    if (r) begin
      x.busy = (pos != 0);
      x.outv = (pos == taps + 2);
      if (pos >= 2 && pos <= taps + 1) x.addr = AW'(pos - 2);
      if (e) begin
        x.ready = (pos == 0);
        x.shift = (pos == 1);
        x.clr   = (pos == 2);
        x.acc   = (pos > 2 && pos <= taps + 1);
      end
    end
    return x;
  endfunction

  function automatic int advance(input int pos, input int taps, input logic r,
                                 input logic e, input logic v, input logic o);
    if (!r) return 0;
    if (!e) return pos;
    if (pos == 0) return v ? 1 : 0;
    if (pos == taps + 2) return o ? 0 : pos;
    return pos + 1;
  endfunction

  // Drive one cycle of inputs and queue what both instances must show.
  task automatic step(input logic r, input logic e, input logic v, input logic o);
    @(posedge clk);
    #1;
    rst_an = r; ena = e; valid = v; out_ready = o;
    q0.push_back(expect_of(pos0, T0, r, e));
    q1.push_back(expect_of(pos1, T1, r, e));
    pos0 = advance(pos0, T0, r, e, v, o);
    pos1 = advance(pos1, T1, r, e, v, o);
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare each presented cycle against the queued expectation.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '{rdy0, busy0, shift0, clr0, acc0, ov0, addr0};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL taps4_outputs cycle %0d: got rdy/busy/sh/clr/acc/ov/addr=%b, expected %b",
                   cyc, a, e);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '{rdy1, busy1, shift1, clr1, acc1, ov1, addr1};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL taps1_outputs cycle %0d: got rdy/busy/sh/clr/acc/ov/addr=%b, expected %b",
                   cyc, a, e);
        end
      end
      if (rst_an && ena && out_ready && ov0) hs0++;
      if (rst_an && ena && out_ready && ov1) hs1++;
    end
  end

  // Stimulus: directed scenarios followed by a randomized stream.
  initial begin
    int base0;
    int base1;
    // reset
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    // single sample
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    // backpressure in DONE
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    // enable freeze at tap address 2
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    // reset mid-MAC at tap address 1
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    // continuous streaming from a clean reset
    step(1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    base0 = hs0;
    base1 = hs1;
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check_int("stream_results_taps4", hs0 - base0, 10);
    check_int("stream_results_taps1", hs1 - base1, 17);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 8)   ? 1'b1 : 1'b0,
           ($urandom_range(0, 1) == 1)  ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 6)   ? 1'b1 : 1'b0);
    end
    settle();
    check_int("queue_drained_taps4", q0.size(), 0);
    check_int("queue_drained_taps1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
